// File: rtl/fc_choice_pkg.sv
// Shared types and helpers for free-choice arbitration in front of the MSFSM modules.
package fc_choice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } fc_state_e;

  localparam int DEF_N_TRANS        = 2;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int FC_MAX_TRANS       = 8;

  function automatic logic [FC_MAX_TRANS-1:0] onehot_from_idx(input logic [2:0] idx);
    return {{(FC_MAX_TRANS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/fc_choice_picker.sv
// Combinational winner selection among requesting transitions.
// FC_CHOICE_ROUND_ROBIN_EN selects cyclic search after ptr_i; otherwise lowest index wins.
module fc_choice_picker #(
  parameter int N_TRANS = 2,
  parameter int IDX_W   = 1
) (
  input  logic [N_TRANS-1:0] req_i,
`ifdef FC_CHOICE_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]   ptr_i,
`endif
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               win_vld_o
);

`ifdef FC_CHOICE_ROUND_ROBIN_EN
  int best;
  int dist;

  // Distance 0 is the index just after the pointer; the nearest requester wins.
  always_comb begin
    win_idx_o = '0;
    win_vld_o = 1'b0;
    best      = N_TRANS;
    dist      = 0;
    for (int i = 0; i < N_TRANS; i++) begin
      dist = (i + 2 * N_TRANS - 1 - int'(ptr_i)) % N_TRANS;
      if (req_i[i] && (dist < best)) begin
        best      = dist;
        win_idx_o = IDX_W'(i);
        win_vld_o = 1'b1;
      end
    end
  end
`else
  // Descending scan so the lowest requesting index is the last to overwrite.
  always_comb begin
    win_idx_o = '0;
    win_vld_o = 1'b0;
    for (int i = N_TRANS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_idx_o = IDX_W'(i);
        win_vld_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fc_choice_arbiter.sv
// Commits one transition of a free-choice place as a held one-hot fire vector until the token is consumed.
// Optional FC_CHOICE_ROUND_ROBIN_EN adds a round-robin pointer in place of fixed priority.
module fc_choice_arbiter
  import fc_choice_pkg::*;
#(
  parameter int N_TRANS        = DEF_N_TRANS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int IDX_W          = (N_TRANS > 1) ? $clog2(N_TRANS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pre_place,
  input  logic [N_TRANS-1:0] req,
  output logic [N_TRANS-1:0] fire,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               err_timeout
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  fc_state_e              state_q, state_d;
  logic [N_TRANS-1:0]     fire_q, fire_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_vld;
  logic [FC_MAX_TRANS-1:0] win_oh;

`ifdef FC_CHOICE_ROUND_ROBIN_EN
  logic [IDX_W-1:0]       ptr_q, ptr_d;
`endif

  fc_choice_picker #(
    .N_TRANS (N_TRANS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i     (req),
`ifdef FC_CHOICE_ROUND_ROBIN_EN
    .ptr_i     (ptr_q),
`endif
    .win_idx_o (win_idx),
    .win_vld_o (win_vld)
  );

  assign win_oh = onehot_from_idx(3'(win_idx));

  always_comb begin
    state_d = state_q;
    fire_d  = fire_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef FC_CHOICE_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        fire_d = '0;
        if (pre_place && win_vld) begin
          fire_d  = win_oh[N_TRANS-1:0];
          grant_d = win_idx;
          cnt_d   = '0;
          state_d = ST_FIRE;
`ifdef FC_CHOICE_ROUND_ROBIN_EN
          ptr_d   = win_idx;
`endif
        end
      end
      ST_FIRE: begin
        if (!pre_place) begin
          fire_d  = '0;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          // fire stays held even after a stall; the barrier may still release.
          if (cnt_q < TO_LIM) cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_LIM) err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        fire_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        fire_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fire_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef FC_CHOICE_ROUND_ROBIN_EN
      ptr_q   <= IDX_W'(N_TRANS - 1);
`endif
    end else begin
      state_q <= state_d;
      fire_q  <= fire_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef FC_CHOICE_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign fire        = fire_q;
  assign grant_idx   = grant_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

`ifndef SYNTHESIS
  fire_onehot0_a : assert property (@(posedge clk) disable iff (reset) $onehot0(fire));
`endif

endmodule
